// File: rtl/fetch_unit_pkg.sv
// Shared constants and the fetch FSM state encoding for the instruction-fetch stage.
package fetch_unit_pkg;
    localparam int              ADDR_W_DEF    = 32;
    localparam int              INSTR_W_DEF   = 32;
    localparam int              OPC_W         = 7;
    localparam logic [31:0]     RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FULL,
        ST_DISCARD
    } fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack bus: fetch side is master, memory side is slave.
interface fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// One {valid, pc, instr} pipeline entry with load/hold/flush; used for IF/ID and the skid slot.
module if_id_reg #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               valid_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o
);
    logic               valid_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] instr_q;

    // Flush beats load so a redirect always leaves a bubble behind.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            valid_q <= valid_i;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake, feeds IF/ID.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    fetch_unit_if.master       imem,
    output logic               if_id_valid,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [OPC_W-1:0]   if_id_opcode
);
    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, addr_q, addr_d;
    logic               req_q, req_d;
    logic               ack, issue;
    logic               ifid_load, ifid_flush, skid_load, skid_flush, use_skid;
    logic               skid_valid;
    logic [ADDR_W-1:0]  skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    // An ack only counts against an outstanding request.
    assign ack = imem.imem_ack & req_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        issue      = 1'b0;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        skid_load  = 1'b0;
        skid_flush = 1'b0;
        use_skid   = 1'b0;
        if (redirect_i) begin
            ifid_flush = 1'b1;
            skid_flush = 1'b1;
            pc_d       = redirect_pc_i;
            // A request still in flight must be drained before refetching.
            if (req_q && !ack) begin
                state_d = ST_DISCARD;
            end else begin
                state_d = ST_RUN;
                req_d   = 1'b0;
            end
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN: begin
                    if (ack && stall_i) begin
                        skid_load = 1'b1;
                        req_d     = 1'b0;
                        state_d   = ST_FULL;
                    end else begin
                        ifid_load = ack;
                        issue     = !req_q || ack;
                    end
                end
                ST_FULL: begin
                    if (!stall_i) begin
                        ifid_load  = 1'b1;
                        use_skid   = 1'b1;
                        skid_flush = 1'b1;
                        issue      = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
                ST_DISCARD: begin
                    if (ack) begin
                        issue   = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
        if (issue) begin
            req_d  = 1'b1;
            addr_d = pc_q;
            pc_d   = pc_q + ADDR_W'(4);
        end
    end

    if_id_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clk     (clk),
        .arst    (arst),
        .load_i  (skid_load),
        .flush_i (skid_flush),
        .valid_i (1'b1),
        .pc_i    (addr_q),
        .instr_i (imem.imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    if_id_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk     (clk),
        .arst    (arst),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .valid_i (use_skid ? skid_valid : 1'b1),
        .pc_i    (use_skid ? skid_pc : addr_q),
        .instr_i (use_skid ? skid_instr : imem.imem_rdata),
        .valid_o (if_id_valid),
        .pc_o    (if_id_pc),
        .instr_o (if_id_instr)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign if_id_opcode   = if_id_instr[OPC_W-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait stream, stall/skid, redirects, reset, PC wrap.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        arst;
    logic        stall_i, redirect_i, ack_en;
    logic [31:0] redirect_pc_i;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instr;
    logic [6:0]  if_id_opcode;
    int          n_chk = 0;
    int          n_fail = 0;

    fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) imem ();

    fetch_unit dut (
        .clk           (clk),
        .arst          (arst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (imem),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_opcode  (if_id_opcode)
    );

    always #5 clk = ~clk;

    // Memory image: address 0 holds 32'h002081B3, others differ in the upper bits only.
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return 32'h002081B3 ^ {a[19:0], 12'h000};
    endfunction

    assign imem.imem_ack   = ack_en & imem.imem_req;
    assign imem.imem_rdata = instr_at(imem.imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; ack_en = 1'b0;
        #1;
        chk("rst_req",   {31'd0, imem.imem_req}, 32'd0);
        chk("rst_addr",  imem.imem_addr, 32'h0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_pc",    if_id_pc, 32'h0);
        chk("rst_instr", if_id_instr, 32'h00000013);
        tick(); tick();
        arst = 1'b0;
        tick();                                   // BOOT -> RUN, no request yet
        chk("boot_noreq", {31'd0, imem.imem_req}, 32'd0);
        ack_en = 1'b1;
        tick();
        chk("s_req0",  {31'd0, imem.imem_req}, 32'd1);
        chk("s_addr0", imem.imem_addr, 32'h0);
        tick();
        chk("s_addr4",   imem.imem_addr, 32'h4);
        chk("s_ifpc0",   if_id_pc, 32'h0);
        chk("s_valid0",  {31'd0, if_id_valid}, 32'd1);
        chk("s_instr0",  if_id_instr, 32'h002081B3);
        chk("s_opcode0", {25'd0, if_id_opcode}, 32'h33);
        tick();
        chk("s_addr8", imem.imem_addr, 32'h8);
        chk("s_ifpc4", if_id_pc, 32'h4);
        chk("s_instr4", if_id_instr, instr_at(32'h4));

        // stall for 3 cycles while addr 8 is acked: goes to skid
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_noreq", {31'd0, imem.imem_req}, 32'd0);
            chk("st_ifpc4", if_id_pc, 32'h4);
        end
        stall_i = 1'b0;
        tick();
        chk("st_ifpc8", if_id_pc, 32'h8);
        chk("st_instr8", if_id_instr, instr_at(32'h8));
        chk("st_reqC", {31'd0, imem.imem_req}, 32'd1);
        chk("st_addrC", imem.imem_addr, 32'hC);
        tick();
        chk("r_ifpcC", if_id_pc, 32'hC);
        chk("r_addr10", imem.imem_addr, 32'h10);

        // redirect to 0x40 while addr 0x10 is pending and unacked
        ack_en = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        chk("r_valid0", {31'd0, if_id_valid}, 32'd0);
        chk("r_nop",    if_id_instr, 32'h00000013);
        chk("r_pc0",    if_id_pc, 32'h0);
        chk("r_hold10", imem.imem_addr, 32'h10);
        tick();
        chk("r_still10", imem.imem_addr, 32'h10);
        ack_en = 1'b1;
        tick();
        chk("r_drop",   {31'd0, if_id_valid}, 32'd0);
        chk("r_addr40", imem.imem_addr, 32'h40);
        tick();
        chk("r_ifpc40",  if_id_pc, 32'h40);
        chk("r_instr40", if_id_instr, instr_at(32'h40));
        chk("r_addr44",  imem.imem_addr, 32'h44);

        // redirect and stall together: flush wins
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0; stall_i = 1'b0;
        chk("rs_valid0", {31'd0, if_id_valid}, 32'd0);
        chk("rs_nop",    if_id_instr, 32'h00000013);
        chk("rs_noreq",  {31'd0, imem.imem_req}, 32'd0);
        tick();
        chk("rs_req",     {31'd0, imem.imem_req}, 32'd1);
        chk("rs_addr100", imem.imem_addr, 32'h100);
        tick();
        chk("rs_ifpc100", if_id_pc, 32'h100);

        // async reset mid-request
        chk("ar_pre_req", {31'd0, imem.imem_req}, 32'd1);
        arst = 1'b1;
        #1;
        chk("ar_req0",   {31'd0, imem.imem_req}, 32'd0);
        chk("ar_valid0", {31'd0, if_id_valid}, 32'd0);
        chk("ar_addr0",  imem.imem_addr, 32'h0);
        tick();
        arst = 1'b0;
        tick();
        chk("ar_boot", {31'd0, imem.imem_req}, 32'd0);
        tick();
        chk("ar_req1",  {31'd0, imem.imem_req}, 32'd1);
        chk("ar_addr0b", imem.imem_addr, 32'h0);

        // PC wrap
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        tick();
        chk("w_addrFC", imem.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("w_ifpcFC", if_id_pc, 32'hFFFF_FFFC);
        chk("w_addr0",  imem.imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
